// File: rtl/kvs_vs_regex_pkg.sv
// Shared types and defaults for the KVS value-search regex feeder.
// Holds the feeder FSM encoding and the config word layout.
package kvs_vs_regex_pkg;

    localparam int DEF_DATA_WIDTH    = 512;
    localparam int DEF_META_WIDTH    = 64;
    localparam int DEF_MAX_INFLIGHT  = 16;
    localparam int DEF_INFLIGHT_BITS = 5;
    localparam int CFG_BROADCAST_BIT = 511;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        CFG
    } feeder_state_e;

endpackage

// File: rtl/kvs_vs_meta_fifo.sv
// Synchronous metadata FIFO holding one entry per in-flight value.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module kvs_vs_meta_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy follows the push/pop pair.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/kvs_vs_regex_feeder.sv
// Feeds value beats and config words to the regex top, pairs results with metadata.
// Optional KVS_VS_FEEDER_STATS_EN adds entry and match counters.
module kvs_vs_regex_feeder
    import kvs_vs_regex_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int META_WIDTH    = DEF_META_WIDTH,
    parameter int MAX_INFLIGHT  = DEF_MAX_INFLIGHT,
    parameter int INFLIGHT_BITS = DEF_INFLIGHT_BITS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_WIDTH-1:0]    value_data,
    input  logic [META_WIDTH-1:0]    value_meta,
    input  logic                     value_valid,
    input  logic                     value_last,
    output logic                     value_ready,
    input  logic [DATA_WIDTH-1:0]    cfg_data,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic [DATA_WIDTH-1:0]    rx_input_data,
    output logic                     rx_input_valid,
    output logic                     rx_input_last,
    input  logic                     rx_input_ready,
    output logic [DATA_WIDTH-1:0]    rx_config_data,
    output logic                     rx_config_valid,
    input  logic                     rx_config_ready,
    input  logic                     rx_found_loc,
    input  logic                     rx_found_valid,
    output logic                     rx_found_ready,
    output logic [META_WIDTH-1:0]    res_meta,
    output logic                     res_match,
    output logic                     res_valid,
    input  logic                     res_ready,
`ifdef KVS_VS_FEEDER_STATS_EN
    output logic [31:0]              stat_entries,
    output logic [31:0]              stat_matches,
`endif
    output logic [INFLIGHT_BITS-1:0] inflight,
    output logic                     err_orphan
);

    localparam logic [INFLIGHT_BITS-1:0] MAX_CNT = INFLIGHT_BITS'(MAX_INFLIGHT);

    feeder_state_e state_q, state_d;
    logic                  started_q;
    logic [DATA_WIDTH-1:0] cfg_q;
    logic                  in_valid_q;
    logic [DATA_WIDTH-1:0] in_data_q;
    logic                  in_last_q;
    logic                  res_valid_q;
    logic [META_WIDTH-1:0] res_meta_q;
    logic                  res_match_q;
    logic                  orphan_q;
    logic [META_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  in_free;
    logic                  first_ok;
    logic                  v_hs;
    logic                  push;
    logic                  f_hs;
    logic                  pop;
    logic                  r_hs;

    assign in_free  = !in_valid_q || rx_input_ready;
    assign first_ok = (inflight < MAX_CNT) && !fifo_full;
    assign v_hs     = value_valid && value_ready;
    assign push     = v_hs && (state_q == IDLE);
    assign f_hs     = rx_found_valid && rx_found_ready;
    assign pop      = f_hs && !fifo_empty;
    assign r_hs     = res_valid_q && res_ready;

    assign rx_input_data   = in_data_q;
    assign rx_input_valid  = in_valid_q;
    assign rx_input_last   = in_last_q;
    assign rx_config_data  = cfg_q;
    assign rx_config_valid = (state_q == CFG);
    assign rx_found_ready  = !res_valid_q || res_ready;
    assign res_meta        = res_meta_q;
    assign res_match       = res_match_q;
    assign res_valid       = res_valid_q;
    assign err_orphan      = orphan_q;

    kvs_vs_meta_fifo #(
        .W     (META_WIDTH),
        .DEPTH (MAX_INFLIGHT),
        .CW    (INFLIGHT_BITS)
    ) u_meta_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .din_i   (value_meta),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (inflight)
    );

    // Next state and handshake readies; config only enters between entries.
    always_comb begin
        state_d     = state_q;
        value_ready = 1'b0;
        cfg_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d = DRAIN;
                end else begin
                    value_ready = started_q && in_free && first_ok;
                    if (value_valid && started_q && in_free && first_ok
                        && !value_last)
                        state_d = STREAM;
                end
            end
            STREAM: begin
                value_ready = in_free;
                if (value_valid && in_free && value_last)
                    state_d = IDLE;
            end
            DRAIN: begin
                if (!cfg_valid) begin
                    state_d = IDLE;
                end else if (inflight == '0 && !in_valid_q) begin
                    cfg_ready = 1'b1;
                    state_d   = CFG;
                end
            end
            CFG: begin
                if (rx_config_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM register; started_q holds value_ready low until out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (cfg_ready) cfg_q <= cfg_data;
        end
    end

    // One-deep output register towards the regex input port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            in_last_q  <= 1'b0;
        end else if (v_hs) begin
            in_valid_q <= 1'b1;
            in_data_q  <= value_data;
            in_last_q  <= value_last;
        end else if (rx_input_ready) begin
            in_valid_q <= 1'b0;
        end
    end

    // Result stage; a result with no pending metadata is dropped and flagged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= 1'b0;
            res_meta_q  <= '0;
            res_match_q <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            if (pop) begin
                res_valid_q <= 1'b1;
                res_meta_q  <= fifo_dout;
                res_match_q <= rx_found_loc;
            end else if (r_hs) begin
                res_valid_q <= 1'b0;
            end
            if (f_hs && fifo_empty) orphan_q <= 1'b1;
        end
    end

`ifdef KVS_VS_FEEDER_STATS_EN
    logic [31:0] ent_q;
    logic [31:0] mat_q;

    assign stat_entries = ent_q;
    assign stat_matches = mat_q;

    // Wrapping activity counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_q <= '0;
            mat_q <= '0;
        end else begin
            if (push) ent_q <= ent_q + 32'd1;
            if (r_hs && res_match_q) mat_q <= mat_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kvs_vs_regex_feeder.sv
// Self-checking bench for kvs_vs_regex_feeder.
// Directed tables and sequences plus a randomized scoreboard run.
module tb_kvs_vs_regex_feeder;

    logic         clk = 1'b0;
    logic         rstn;
    logic [511:0] value_data;
    logic [63:0]  value_meta;
    logic         value_valid;
    logic         value_last;
    logic         value_ready;
    logic [511:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [511:0] rx_input_data;
    logic         rx_input_valid;
    logic         rx_input_last;
    logic         rx_input_ready;
    logic [511:0] rx_config_data;
    logic         rx_config_valid;
    logic         rx_config_ready;
    logic         rx_found_loc;
    logic         rx_found_valid;
    logic         rx_found_ready;
    logic [63:0]  res_meta;
    logic         res_match;
    logic         res_valid;
    logic         res_ready;
    logic [4:0]   inflight;
    logic         err_orphan;
`ifdef KVS_VS_FEEDER_STATS_EN
    logic [31:0]  stat_entries;
    logic [31:0]  stat_matches;
`endif

    int checks = 0;
    int errors = 0;

    kvs_vs_regex_feeder dut (
        .clk             (clk),
        .rstn            (rstn),
        .value_data      (value_data),
        .value_meta      (value_meta),
        .value_valid     (value_valid),
        .value_last      (value_last),
        .value_ready     (value_ready),
        .cfg_data        (cfg_data),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .rx_input_data   (rx_input_data),
        .rx_input_valid  (rx_input_valid),
        .rx_input_last   (rx_input_last),
        .rx_input_ready  (rx_input_ready),
        .rx_config_data  (rx_config_data),
        .rx_config_valid (rx_config_valid),
        .rx_config_ready (rx_config_ready),
        .rx_found_loc    (rx_found_loc),
        .rx_found_valid  (rx_found_valid),
        .rx_found_ready  (rx_found_ready),
        .res_meta        (res_meta),
        .res_match       (res_match),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
`ifdef KVS_VS_FEEDER_STATS_EN
        .stat_entries    (stat_entries),
        .stat_matches    (stat_matches),
`endif
        .inflight        (inflight),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] meta;
        int          nb;
        logic        fnd;
    } ent_t;

    typedef struct {
        logic [511:0] d;
        logic         l;
        logic         f;
        logic [63:0]  meta;
    } beat_t;

    typedef struct {
        logic vv;
        logic cv;
        logic ir;
        logic rr;
        logic fv;
        logic e_vr;
        logic e_fr;
        logic e_cr;
    } vec_t;

    ent_t  ents[$];
    beat_t bq[$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] got,
                        input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        value_data      = '0;
        value_meta      = '0;
        value_valid     = 1'b0;
        value_last      = 1'b0;
        cfg_data        = '0;
        cfg_valid       = 1'b0;
        rx_input_ready  = 1'b0;
        rx_config_ready = 1'b0;
        rx_found_loc    = 1'b0;
        rx_found_valid  = 1'b0;
        res_ready       = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        clr_inputs();
        rstn = 1'b0;
        #1;
        if (check) begin
            chk("rst_value_ready", value_ready, 0);
            chk("rst_cfg_ready", cfg_ready, 0);
            chk("rst_in_valid", rx_input_valid, 0);
            chk("rst_cfg_valid", rx_config_valid, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_orphan", err_orphan, 0);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        step();
    endtask

    task automatic send_beat(input logic [63:0] m, input logic [511:0] d,
                             input logic l);
        int n;
        value_valid = 1'b1;
        value_meta  = m;
        value_data  = d;
        value_last  = l;
        n = 0;
        while (!value_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("send_timeout", 0, 1);
        step();
        value_valid = 1'b0;
    endtask

    task automatic add_entry(input logic [63:0] m, input int nb,
                             input logic fnd);
        ent_t  e;
        beat_t b;
        e.meta = m;
        e.nb   = nb;
        e.fnd  = fnd;
        ents.push_back(e);
        for (int i = 0; i < nb; i++) begin
            b.d    = rnd512();
            b.l    = (i == nb - 1);
            b.f    = (i == 0);
            b.meta = m;
            bq.push_back(b);
        end
    endtask

    // Drives entries, mocks the regex top in order, scores the result stream.
    task automatic run_stream(input int pv, input int pi, input int pf,
                              input int pr, input bit hold, input int budget,
                              output int peak);
        int bi, oi, fo, fs, ri, minfl, cyc, ne, nbt;
        bit vhs, ihs, fhs, rhs;
        bi = 0; oi = 0; fo = 0; fs = 0; ri = 0;
        minfl = 0; cyc = 0; peak = 0;
        ne  = ents.size();
        nbt = bq.size();
        while (ri < ne && cyc < budget) begin
            @(negedge clk);
            vhs = value_valid && value_ready;
            ihs = rx_input_valid && rx_input_ready;
            fhs = rx_found_valid && rx_found_ready;
            rhs = res_valid && res_ready;
            chk("rs_inflight", inflight, 64'(minfl));
            if (ihs) begin
                chkw("rs_in_data", rx_input_data, bq[oi].d);
                chk("rs_in_last", rx_input_last, bq[oi].l);
                if (bq[oi].l) fo++;
                oi++;
            end
            if (fhs) begin
                fs++;
                minfl--;
            end
            if (vhs) begin
                if (bq[bi].f) minfl++;
                bi++;
            end
            if (minfl > peak) peak = minfl;
            if (rhs) begin
                chk("rs_res_meta", res_meta, ents[ri].meta);
                chk("rs_res_match", res_match, ents[ri].fnd);
                ri++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!value_valid || vhs) begin
                if (bi < nbt && $urandom_range(99) < pv) begin
                    value_valid = 1'b1;
                    value_data  = bq[bi].d;
                    value_last  = bq[bi].l;
                    value_meta  = bq[bi].f ? bq[bi].meta
                                           : {$urandom, $urandom};
                end else begin
                    value_valid = 1'b0;
                end
            end
            rx_input_ready = ($urandom_range(99) < pi);
            if (!rx_found_valid || fhs) begin
                if (fs < fo && (!hold || fo == ne)
                    && $urandom_range(99) < pf) begin
                    rx_found_valid = 1'b1;
                    rx_found_loc   = ents[fs].fnd;
                end else begin
                    rx_found_valid = 1'b0;
                end
            end
            res_ready = ($urandom_range(99) < pr);
        end
        chk("rs_all_results", 64'(ri), 64'(ne));
        clr_inputs();
        step();
        chk("rs_end_inflight", inflight, 0);
        chk("rs_end_orphan", err_orphan, 0);
    endtask

    vec_t vt[6];

    initial begin
        int peak;
        int acc;
        int pulses;
        bit seen;
        logic [511:0] cfgw;

        vt[0] = '{0, 0, 0, 0, 0, 1, 1, 0};
        vt[1] = '{1, 0, 0, 0, 0, 1, 1, 0};
        vt[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
        vt[3] = '{1, 1, 1, 1, 1, 0, 1, 0};
        vt[4] = '{1, 0, 1, 0, 1, 1, 1, 0};
        vt[5] = '{0, 0, 1, 1, 0, 1, 1, 0};

        do_reset(1);

        // Idle readiness table; inputs withdrawn before each edge.
        for (int i = 0; i < 6; i++) begin
            value_valid    = vt[i].vv;
            cfg_valid      = vt[i].cv;
            rx_input_ready = vt[i].ir;
            res_ready      = vt[i].rr;
            rx_found_valid = vt[i].fv;
            #1;
            chk("tbl_value_ready", value_ready, vt[i].e_vr);
            chk("tbl_found_ready", rx_found_ready, vt[i].e_fr);
            chk("tbl_cfg_ready", cfg_ready, vt[i].e_cr);
            clr_inputs();
            step();
        end
        chk("tbl_no_orphan", err_orphan, 0);

        // Three entries, results held until all sent.
        do_reset(0);
        ents.delete();
        bq.delete();
        add_entry(64'hA, 2, 1'b1);
        add_entry(64'hB, 1, 1'b0);
        add_entry(64'hC, 3, 1'b1);
        run_stream(100, 100, 100, 100, 1, 200, peak);
        chk("three_peak", 64'(peak), 3);

        // Inflight limit at sixteen.
        do_reset(0);
        value_valid    = 1'b1;
        value_last     = 1'b1;
        rx_input_ready = 1'b1;
        res_ready      = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            value_meta = 64'(100 + acc);
            if (value_ready) acc++;
            step();
        end
        value_meta = 64'(100 + acc);
        chk("lim_accepted", 64'(acc), 16);
        chk("lim_vready", value_ready, 0);
        chk("lim_inflight", inflight, 16);
        rx_found_valid = 1'b1;
        rx_found_loc   = 1'b1;
        chk("lim_fready", rx_found_ready, 1);
        step();
        rx_found_valid = 1'b0;
        chk("lim_res_valid", res_valid, 1);
        chk("lim_res_meta", res_meta, 100);
        chk("lim_res_match", res_match, 1);
        chk("lim_vready_again", value_ready, 1);
        step();
        value_valid = 1'b0;
        chk("lim_inflight_16", inflight, 16);
        chk("lim_vready_full", value_ready, 0);

        // Config request mid entry drains first.
        do_reset(0);
        rx_input_ready  = 1'b1;
        res_ready       = 1'b1;
        rx_config_ready = 1'b1;
        send_beat(64'h11, rnd512(), 1'b1);
        send_beat(64'h12, rnd512(), 1'b1);
        send_beat(64'h13, rnd512(), 1'b0);
        cfgw = '0;
        cfgw[511] = 1'b1;
        cfgw[0] = 1'b1;
        cfg_data  = cfgw;
        cfg_valid = 1'b1;
        #1;
        chk("cfg_stream_vready", value_ready, 1);
        send_beat(64'h0, rnd512(), 1'b0);
        send_beat(64'h0, rnd512(), 1'b0);
        send_beat(64'h0, rnd512(), 1'b1);
        chk("cfg_idle_vready", value_ready, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (cfg_ready) pulses++;
            if (rx_config_valid) pulses++;
            step();
        end
        chk("drain_holds", 64'(pulses), 0);
        chk("drain_inflight", inflight, 3);
        chk("drain_vready", value_ready, 0);
        rx_found_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_found_loc = (i != 1);
            step();
            chk("drain_res_meta", res_meta, 64'(17 + i));
            chk("drain_res_match", res_match, 64'(i != 1));
        end
        rx_found_valid = 1'b0;
        pulses = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cfg_ready) pulses++;
            if (rx_config_valid) begin
                seen = 1'b1;
                chkw("cfg_data_out", rx_config_data, cfgw);
            end
            step();
            if (pulses > 0) cfg_valid = 1'b0;
        end
        chk("cfg_pulse_once", 64'(pulses), 1);
        chk("cfg_seen", 64'(seen), 1);
        chk("cfg_back_idle", rx_config_valid, 0);

        // Result backpressure.
        do_reset(0);
        rx_input_ready = 1'b1;
        send_beat(64'h21, rnd512(), 1'b1);
        send_beat(64'h22, rnd512(), 1'b1);
        rx_found_valid = 1'b1;
        rx_found_loc   = 1'b1;
        step();
        rx_found_loc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_meta", res_meta, 64'h21);
            chk("bp_fready", rx_found_ready, 0);
            chk("bp_inflight", inflight, 1);
            step();
        end
        res_ready = 1'b1;
        step();
        rx_found_valid = 1'b0;
        chk("bp_second_meta", res_meta, 64'h22);
        chk("bp_second_match", res_match, 0);
        step();
        chk("bp_drained", res_valid, 0);
        chk("bp_inflight0", inflight, 0);

        // Orphan result.
        do_reset(0);
        rx_found_valid = 1'b1;
        rx_found_loc   = 1'b1;
        chk("orph_fready", rx_found_ready, 1);
        step();
        rx_found_valid = 1'b0;
        step();
        step();
        chk("orph_flag", err_orphan, 1);
        chk("orph_res_valid", res_valid, 0);
        chk("orph_inflight", inflight, 0);

        // Reset in the middle of an entry.
        do_reset(1);
        rx_input_ready = 1'b1;
        res_ready      = 1'b1;
        send_beat(64'h99, rnd512(), 1'b0);
        value_valid = 1'b1;
        value_data  = rnd512();
        value_last  = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_in_valid", rx_input_valid, 0);
        chk("mid_vready", value_ready, 0);
        chk("mid_inflight", inflight, 0);
        chk("mid_res_valid", res_valid, 0);
        value_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        step();
        send_beat(64'hD, rnd512(), 1'b1);
        step();
        rx_found_valid = 1'b1;
        rx_found_loc   = 1'b1;
        step();
        rx_found_valid = 1'b0;
        chk("mid_res_meta", res_meta, 64'hD);
        chk("mid_res_match", res_match, 1);
        step();
        chk("mid_res_done", res_valid, 0);
        chk("mid_inflight0", inflight, 0);

        // Randomized traffic, moderate and heavy backpressure.
        for (int r = 0; r < 2; r++) begin
            do_reset(0);
            ents.delete();
            bq.delete();
            for (int i = 0; i < 40; i++)
                add_entry({$urandom, $urandom}, $urandom_range(4, 1),
                          1'($urandom_range(1)));
            if (r == 0) run_stream(70, 60, 50, 60, 0, 4000, peak);
            else        run_stream(90, 25, 80, 20, 0, 8000, peak);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
